usys_pe_inner: RTL and testbench
================================

Name: usys_pe_inner

Overview:
- Inner datapath of one unary-systolic GEMM processing element.
- Holds a sign-magnitude binary weight and multiplies it against a sign-magnitude unary input bitstream, one bit per cycle.
- The weight becomes a bitstream by comparison with a pass-by random number; signed product bits are accumulated.
- On the end-of-stream marker, adds the incoming neighbour partial sum and registers the result for the next PE.
- Weight, input, random numbers and M_end are registered so they can be forwarded along the array.

Parameters:
- BINARY_WEIGHT_BITWIDTH, 4: weight width including sign; magnitude is BINARY_WEIGHT_BITWIDTH-1 bits.
- BINARY_RANDOM_NUM_BITWIDTH, 3: random number width; must equal BINARY_WEIGHT_BITWIDTH-1.
- BINARY_OUTPUT_BITWIDTH, 8: two's-complement partial sum width.
- M_END_BITWIDTH, 1: width of the end-of-stream marker.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  synchronous reset, active-high (asserted = 1, despite the name)
- b_weight_abs  in  BINARY_WEIGHT_BITWIDTH-1  weight magnitude
- b_weight_sign  in  1  weight sign (1 = negative)
- b_weight_abs_reg  out  BINARY_WEIGHT_BITWIDTH-1  stored weight magnitude
- b_weight_sign_reg  out  1  stored weight sign
- u_input_abs  in  1  unary input magnitude bit
- u_input_sign  in  1  input sign
- u_input_abs_reg  out  1  registered input bit
- u_input_sign_reg  out  1  registered input sign
- b_w_rand_num_passby  in  BINARY_RANDOM_NUM_BITWIDTH  weight random number
- b_w_rand_num_reg  out  BINARY_RANDOM_NUM_BITWIDTH  registered weight random number
- b_i_rand_num_passby  in  BINARY_RANDOM_NUM_BITWIDTH  input random number (forwarded only)
- b_i_rand_num_reg  out  BINARY_RANDOM_NUM_BITWIDTH  registered input random number
- b_output_passby  in  BINARY_OUTPUT_BITWIDTH  neighbour partial sum
- b_output_reg  out  BINARY_OUTPUT_BITWIDTH  registered partial sum
- weight_reg_en, weight_reg_r0w1  in  1 each  weight register control
- input_reg_en, input_reg_r0w1  in  1 each  input register control
- rand_num_reg_en, rand_num_reg_r0w1  in  1 each  random-number register control
- output_num_reg_en, output_num_reg_r0w1  in  1 each  output register control
- M_end  in  M_END_BITWIDTH  last-bit-of-stream marker
- M_end_reg  out  M_END_BITWIDTH  registered M_end

Behaviour:
- Reset: while resetn = 1 at a rising edge, all registers clear to 0. This covers all *_reg outputs, the accumulator acc and the valid flag. Reset mid-stream discards acc.
- Register control, applied to each register group:
  - en=1 and r0w1=1: load the matching input.
  - Any other combination: hold.
  - Groups and sources: weight_reg loads b_weight_abs/sign; input_reg loads u_input_abs/sign; rand_num_reg loads both passby random numbers; output reg is described below.
- Valid flag: valid <= input_reg_en & input_reg_r0w1.
- M_end_reg <= M_end every cycle, unconditionally.
- Combinational product, each cycle:
  - wbit = (b_weight_abs_reg > b_w_rand_num_passby). This uses the unregistered random number.
  - p = u_input_abs_reg & wbit.
  - s = u_input_sign_reg ^ b_weight_sign_reg.
  - delta = (valid & p) ? (s ? -1 : +1) : 0.
- Accumulation:
  - acc_next = acc + delta, wrapping at BINARY_OUTPUT_BITWIDTH bits.
  - If M_end_reg != 0: b_output_reg <= acc_next + b_output_passby, and acc <= 0.
  - Else: acc <= acc_next. If output_num_reg_en & output_num_reg_r0w1, b_output_reg <= b_output_passby; otherwise b_output_reg holds.
  - M_end_reg takes priority over the output load control.
- Latency: an input bit sampled at edge N contributes at edge N+1. M_end sampled with the last bit produces the final sum at the following edge.
- b_i_rand_num_passby never affects arithmetic.

Optional Feature:
- Macro PE_OUTPUT_SATURATE_EN.
- Defined: both acc_next and the final sum saturate to the signed range (-128..127 at the default width).
- Undefined: two's-complement wrap.

Test Plan:
- Reset: resetn=1 for one edge -> all outputs 0; M_end_reg=0; acc=0.
- Weight load: abs=7, sign=0, en=r0w1=1 for one edge, then r0w1=0 -> b_weight_abs_reg=7 held across 16 further cycles.
- Full stream, positive:
  - Stimulus: weight 7; input_abs=1, sign=0, loaded for 16 cycles; both random numbers 0; M_end=1 on the 16th; b_output_passby=63 afterwards.
  - Required: b_output_reg=79 one edge after M_end_reg rises; acc=0 afterwards.
- Negative sign: as the positive stream but u_input_sign=1, passby=0 -> b_output_reg = -16 (0xF0).
- Comparator gating: weight abs=3, random numbers cycling 0..7, input all ones for 8 cycles, passby 0 -> b_output_reg=3.
- Forwarding and saturation:
  - output_num_reg_en=r0w1=1, passby=0x2A, M_end_reg=0 -> b_output_reg=0x2A.
  - With PE_OUTPUT_SATURATE_EN: acc near 127 plus passby 127 -> b_output_reg=127.

Source files
------------

// File: rtl/usys_pe_inner.sv
// ---------------------------------------------------------------------------
// usys_pe_inner
//
// Purpose:
//   Inner datapath of one unary-systolic GEMM processing element. A stored
//   sign-magnitude binary weight is turned into a bitstream by comparing it
//   with a pass-by random number. That bitstream is ANDed with a sign-magnitude
//   unary input bitstream, and the signed product bits are accumulated. On the
//   end-of-stream marker the neighbour partial sum is added and the result is
//   registered for the next PE. Weight, input, random numbers and M_end are
//   registered so they can be forwarded along the array.
//
// Ports:
//   clk, resetn              clock (rising edge); synchronous reset, active-high
//   b_weight_abs/sign        weight magnitude / sign (1 = negative)
//   b_weight_*_reg           stored weight
//   u_input_abs/sign         unary input bit / sign
//   u_input_*_reg            registered input
//   b_w_rand_num_passby      weight random number (used unregistered)
//   b_i_rand_num_passby      input random number (forwarded only)
//   b_*_rand_num_reg         registered random numbers
//   b_output_passby          neighbour partial sum
//   b_output_reg             registered partial sum
//   *_reg_en, *_reg_r0w1     per-group register control (load when both high)
//   M_end, M_end_reg         end-of-stream marker and its registered copy
//
// Configuration:
//   PE_OUTPUT_SATURATE_EN    when defined, the accumulator update and the final
//                            sum saturate to the signed output range; otherwise
//                            they wrap (two's complement).
// ---------------------------------------------------------------------------
module usys_pe_inner #(
  parameter int BINARY_WEIGHT_BITWIDTH     = 4,
  parameter int BINARY_RANDOM_NUM_BITWIDTH = 3,
  parameter int BINARY_OUTPUT_BITWIDTH     = 8,
  parameter int M_END_BITWIDTH             = 1
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [BINARY_WEIGHT_BITWIDTH-2:0]     b_weight_abs,
  input  logic                                  b_weight_sign,
  output logic [BINARY_WEIGHT_BITWIDTH-2:0]     b_weight_abs_reg,
  output logic                                  b_weight_sign_reg,
  input  logic                                  u_input_abs,
  input  logic                                  u_input_sign,
  output logic                                  u_input_abs_reg,
  output logic                                  u_input_sign_reg,
  input  logic [BINARY_RANDOM_NUM_BITWIDTH-1:0] b_w_rand_num_passby,
  output logic [BINARY_RANDOM_NUM_BITWIDTH-1:0] b_w_rand_num_reg,
  input  logic [BINARY_RANDOM_NUM_BITWIDTH-1:0] b_i_rand_num_passby,
  output logic [BINARY_RANDOM_NUM_BITWIDTH-1:0] b_i_rand_num_reg,
  input  logic [BINARY_OUTPUT_BITWIDTH-1:0]     b_output_passby,
  output logic [BINARY_OUTPUT_BITWIDTH-1:0]     b_output_reg,
  input  logic                                  weight_reg_en,
  input  logic                                  weight_reg_r0w1,
  input  logic                                  input_reg_en,
  input  logic                                  input_reg_r0w1,
  input  logic                                  rand_num_reg_en,
  input  logic                                  rand_num_reg_r0w1,
  input  logic                                  output_num_reg_en,
  input  logic                                  output_num_reg_r0w1,
  input  logic [M_END_BITWIDTH-1:0]             M_end,
  output logic [M_END_BITWIDTH-1:0]             M_end_reg
);

  localparam int WAW = BINARY_WEIGHT_BITWIDTH - 1;
  localparam int RW  = BINARY_RANDOM_NUM_BITWIDTH;
  localparam int OW  = BINARY_OUTPUT_BITWIDTH;

  logic [WAW-1:0]            weight_abs_q, weight_abs_d;
  logic                      weight_sign_q, weight_sign_d;
  logic                      input_abs_q, input_abs_d;
  logic                      input_sign_q, input_sign_d;
  logic [RW-1:0]             w_rand_q, w_rand_d;
  logic [RW-1:0]             i_rand_q, i_rand_d;
  logic [OW-1:0]             output_q, output_d;
  logic [OW-1:0]             acc_q, acc_d;
  logic                      valid_q, valid_d;
  logic [M_END_BITWIDTH-1:0] m_end_q, m_end_d;

  logic          wbit;
  logic          prod_bit;
  logic          prod_neg;
  logic [OW-1:0] delta;
  logic [OW-1:0] acc_next;

  // Signed add of two output-width values; clamps to the signed range when
  // saturation is enabled, wraps otherwise.
  function automatic logic [OW-1:0] add_out(input logic [OW-1:0] a,
                                            input logic [OW-1:0] b);
`ifdef PE_OUTPUT_SATURATE_EN
    logic [OW:0] ext;
    ext = {a[OW-1], a} + {b[OW-1], b};
    // Overflow shows up as disagreement between the two top bits.
    if (ext[OW] != ext[OW-1])
      add_out = ext[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    else
      add_out = ext[OW-1:0];
`else
    add_out = a + b;
`endif
  endfunction

  // Product bit: the weight becomes a stochastic bit by comparison against the
  // live (unregistered) random number, so neighbouring PEs see the same value.
  always_comb begin
    wbit     = (weight_abs_q > w_rand_q_live());
    prod_bit = input_abs_q & wbit;
    prod_neg = input_sign_q ^ weight_sign_q;
    delta    = '0;
    if (valid_q && prod_bit)
      delta = prod_neg ? {OW{1'b1}} : {{(OW-1){1'b0}}, 1'b1};
    acc_next = add_out(acc_q, delta);
  end

  function automatic logic [RW-1:0] w_rand_q_live();
    w_rand_q_live = b_w_rand_num_passby;
  endfunction

  // Next-state logic: each register group loads only on en & r0w1, otherwise
  // holds. M_end_reg takes priority over the output load control.
  always_comb begin
    weight_abs_d  = weight_abs_q;
    weight_sign_d = weight_sign_q;
    input_abs_d   = input_abs_q;
    input_sign_d  = input_sign_q;
    w_rand_d      = w_rand_q;
    i_rand_d      = i_rand_q;
    output_d      = output_q;
    acc_d         = acc_next;
    valid_d       = input_reg_en & input_reg_r0w1;
    m_end_d       = M_end;

    if (weight_reg_en && weight_reg_r0w1) begin
      weight_abs_d  = b_weight_abs;
      weight_sign_d = b_weight_sign;
    end
    if (input_reg_en && input_reg_r0w1) begin
      input_abs_d  = u_input_abs;
      input_sign_d = u_input_sign;
    end
    if (rand_num_reg_en && rand_num_reg_r0w1) begin
      w_rand_d = b_w_rand_num_passby;
      i_rand_d = b_i_rand_num_passby;
    end

    if (m_end_q != '0) begin
      output_d = add_out(acc_next, b_output_passby);
      acc_d    = '0;
    end else if (output_num_reg_en && output_num_reg_r0w1) begin
      output_d = b_output_passby;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      weight_abs_q  <= '0;
      weight_sign_q <= 1'b0;
      input_abs_q   <= 1'b0;
      input_sign_q  <= 1'b0;
      w_rand_q      <= '0;
      i_rand_q      <= '0;
      output_q      <= '0;
      acc_q         <= '0;
      valid_q       <= 1'b0;
      m_end_q       <= '0;
    end else begin
      weight_abs_q  <= weight_abs_d;
      weight_sign_q <= weight_sign_d;
      input_abs_q   <= input_abs_d;
      input_sign_q  <= input_sign_d;
      w_rand_q      <= w_rand_d;
      i_rand_q      <= i_rand_d;
      output_q      <= output_d;
      acc_q         <= acc_d;
      valid_q       <= valid_d;
      m_end_q       <= m_end_d;
    end
  end

  assign b_weight_abs_reg  = weight_abs_q;
  assign b_weight_sign_reg = weight_sign_q;
  assign u_input_abs_reg   = input_abs_q;
  assign u_input_sign_reg  = input_sign_q;
  assign b_w_rand_num_reg  = w_rand_q;
  assign b_i_rand_num_reg  = i_rand_q;
  assign b_output_reg      = output_q;
  assign M_end_reg         = m_end_q;

endmodule

// File: tb/tb_usys_pe_inner.sv
// ---------------------------------------------------------------------------
// tb_usys_pe_inner
//
// Scoreboard bench for usys_pe_inner. Each stream computes its expected final
// partial sum from the arithmetic rule (sum of signed product bits plus the
// neighbour partial sum) and pushes it into a queue. A monitor pops the queue
// whenever the DUT's registered end-of-stream marker says a result has just
// been registered. Direct register-behaviour checks run inline.
// ---------------------------------------------------------------------------
module tb_usys_pe_inner;

  typedef struct packed {
    logic       resetn;
    logic [2:0] w_abs;
    logic       w_sign;
    logic       in_abs;
    logic       in_sign;
    logic [2:0] w_rand;
    logic [2:0] i_rand;
    logic [7:0] passby;
    logic       w_en;
    logic       w_r0w1;
    logic       in_en;
    logic       in_r0w1;
    logic       r_en;
    logic       r_r0w1;
    logic       o_en;
    logic       o_r0w1;
    logic       m_end;
  } stim_t;

  logic       clk;
  logic       resetn;
  logic [2:0] b_weight_abs;
  logic       b_weight_sign;
  logic [2:0] b_weight_abs_reg;
  logic       b_weight_sign_reg;
  logic       u_input_abs;
  logic       u_input_sign;
  logic       u_input_abs_reg;
  logic       u_input_sign_reg;
  logic [2:0] b_w_rand_num_passby;
  logic [2:0] b_w_rand_num_reg;
  logic [2:0] b_i_rand_num_passby;
  logic [2:0] b_i_rand_num_reg;
  logic [7:0] b_output_passby;
  logic [7:0] b_output_reg;
  logic       weight_reg_en;
  logic       weight_reg_r0w1;
  logic       input_reg_en;
  logic       input_reg_r0w1;
  logic       rand_num_reg_en;
  logic       rand_num_reg_r0w1;
  logic       output_num_reg_en;
  logic       output_num_reg_r0w1;
  logic [0:0] M_end;
  logic [0:0] M_end_reg;

  int         nVec  = 0;
  int         nMiss = 0;
  logic [7:0] expQ[$];

  usys_pe_inner dut (
    .clk                 (clk),
    .resetn              (resetn),
    .b_weight_abs        (b_weight_abs),
    .b_weight_sign       (b_weight_sign),
    .b_weight_abs_reg    (b_weight_abs_reg),
    .b_weight_sign_reg   (b_weight_sign_reg),
    .u_input_abs         (u_input_abs),
    .u_input_sign        (u_input_sign),
    .u_input_abs_reg     (u_input_abs_reg),
    .u_input_sign_reg    (u_input_sign_reg),
    .b_w_rand_num_passby (b_w_rand_num_passby),
    .b_w_rand_num_reg    (b_w_rand_num_reg),
    .b_i_rand_num_passby (b_i_rand_num_passby),
    .b_i_rand_num_reg    (b_i_rand_num_reg),
    .b_output_passby     (b_output_passby),
    .b_output_reg        (b_output_reg),
    .weight_reg_en       (weight_reg_en),
    .weight_reg_r0w1     (weight_reg_r0w1),
    .input_reg_en        (input_reg_en),
    .input_reg_r0w1      (input_reg_r0w1),
    .rand_num_reg_en     (rand_num_reg_en),
    .rand_num_reg_r0w1   (rand_num_reg_r0w1),
    .output_num_reg_en   (output_num_reg_en),
    .output_num_reg_r0w1 (output_num_reg_r0w1),
    .M_end               (M_end),
    .M_end_reg           (M_end_reg)
  );

  // Free-running clock, first rising edge at 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive every input from one stimulus record.
  task automatic driveNow(input stim_t s);
    resetn              = s.resetn;
    b_weight_abs        = s.w_abs;
    b_weight_sign       = s.w_sign;
    u_input_abs         = s.in_abs;
    u_input_sign        = s.in_sign;
    b_w_rand_num_passby = s.w_rand;
    b_i_rand_num_passby = s.i_rand;
    b_output_passby     = s.passby;
    weight_reg_en       = s.w_en;
    weight_reg_r0w1     = s.w_r0w1;
    input_reg_en        = s.in_en;
    input_reg_r0w1      = s.in_r0w1;
    rand_num_reg_en     = s.r_en;
    rand_num_reg_r0w1   = s.r_r0w1;
    output_num_reg_en   = s.o_en;
    output_num_reg_r0w1 = s.o_r0w1;
    M_end               = s.m_end;
  endtask

  // Apply one cycle of stimulus on the falling edge, away from the sampling edge.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    driveNow(s);
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  // Reference accumulator step: saturating or wrapping signed arithmetic.
  function automatic int clampOut(input int v);
`ifdef PE_OUTPUT_SATURATE_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
`endif
    return v;
  endfunction

  // One complete stream. kind 0: all ones, positive, random number 0;
  // kind 1: all ones, negative input; kind 2: all ones, random cycling 0..7;
  // kind 3: fully random bits, signs, random numbers and valid gaps.
  task automatic runStream(input int len, input logic [2:0] wAbs,
                           input logic wSign, input int kind,
                           input logic [7:0] passby);
    stim_t s;
    int    acc;
    logic  prevLoaded, prevAbs, prevSign;
    logic  loaded;
    logic [2:0] r;
    logic [1:0] ctl;
    s = '0;
    s.w_en   = 1'b1;
    s.w_r0w1 = 1'b1;
    s.w_abs  = wAbs;
    s.w_sign = wSign;
    applyStimulus(s);
    acc        = 0;
    prevLoaded = 1'b0;
    prevAbs    = 1'b0;
    prevSign   = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s = '0;
      s.w_en  = 1'($urandom_range(0, 1));
      s.w_abs = 3'($urandom);
      s.w_sign = 1'($urandom);
      case (kind)
        2:       r = 3'(i % 8);
        3:       r = 3'($urandom);
        default: r = 3'd0;
      endcase
      s.w_rand = r;
      s.i_rand = (kind == 3) ? 3'($urandom) : r;
      // The bit loaded last cycle is weighed against this cycle's random number.
      if (prevLoaded && prevAbs && (wAbs > r))
        acc = clampOut(acc + ((prevSign ^ wSign) ? -1 : 1));
      if (i < len) begin
        loaded = (kind == 3) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (loaded) begin
          s.in_en   = 1'b1;
          s.in_r0w1 = 1'b1;
        end else begin
          ctl       = 2'($urandom_range(0, 2));
          s.in_en   = ctl[1];
          s.in_r0w1 = ctl[0];
        end
        s.in_abs  = (kind == 3) ? 1'($urandom) : 1'b1;
        s.in_sign = (kind == 3) ? 1'($urandom) : (kind == 1);
        s.m_end   = (i == len - 1);
        if (kind == 3) begin
          s.passby = 8'($urandom);
          s.o_en   = 1'($urandom);
          s.o_r0w1 = 1'($urandom);
        end
        prevLoaded = loaded;
        prevAbs    = s.in_abs;
        prevSign   = s.in_sign;
      end else begin
        // Result cycle: output-load control must lose to the end marker.
        s.passby = passby;
        s.o_en   = 1'($urandom);
        s.o_r0w1 = 1'($urandom);
        expQ.push_back(8'(clampOut(acc + int'($signed(passby)))));
      end
      applyStimulus(s);
    end
  endtask

  // Monitor: a high M_end_reg before an edge means that edge registers a result.
  initial begin
    logic mendPre;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      mendPre = M_end_reg[0];
      @(posedge clk);
      #1;
      if (mendPre === 1'b1) begin
        if (expQ.size() == 0) begin
          nVec++;
          nMiss++;
          $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result",
                   b_output_reg);
        end else begin
          e = expQ.pop_front();
          checkOutput("stream_sum", 32'(b_output_reg), 32'(e));
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    waitCycles;
    // Reset at the first edge.
    s = '0;
    s.resetn = 1'b1;
    s.passby = 8'h5A;
    s.w_abs  = 3'd5;
    driveNow(s);
    afterEdge();
    checkOutput("rst_w_abs",  32'(b_weight_abs_reg),  32'd0);
    checkOutput("rst_w_sign", 32'(b_weight_sign_reg), 32'd0);
    checkOutput("rst_in_abs", 32'(u_input_abs_reg),   32'd0);
    checkOutput("rst_in_sign",32'(u_input_sign_reg),  32'd0);
    checkOutput("rst_w_rand", 32'(b_w_rand_num_reg),  32'd0);
    checkOutput("rst_i_rand", 32'(b_i_rand_num_reg),  32'd0);
    checkOutput("rst_out",    32'(b_output_reg),      32'd0);
    checkOutput("rst_m_end",  32'(M_end_reg),         32'd0);

    // Weight load then hold for 16 cycles while the input bus changes.
    s = '0;
    s.w_en = 1'b1; s.w_r0w1 = 1'b1; s.w_abs = 3'd7;
    applyStimulus(s);
    for (int i = 0; i < 16; i++) begin
      s = '0;
      s.w_en = 1'b1; s.w_abs = 3'($urandom); s.w_sign = 1'b1;
      applyStimulus(s);
    end
    afterEdge();
    checkOutput("w_hold_abs",  32'(b_weight_abs_reg),  32'd7);
    checkOutput("w_hold_sign", 32'(b_weight_sign_reg), 32'd0);

    // Output forwarding load, then hold when r0w1 is low.
    s = '0;
    s.o_en = 1'b1; s.o_r0w1 = 1'b1; s.passby = 8'h2A;
    applyStimulus(s);
    afterEdge();
    checkOutput("fwd_load", 32'(b_output_reg), 32'h2A);
    s.o_r0w1 = 1'b0; s.passby = 8'h55;
    applyStimulus(s);
    afterEdge();
    checkOutput("fwd_hold", 32'(b_output_reg), 32'h2A);

    // Random-number register load, then hold.
    s = '0;
    s.r_en = 1'b1; s.r_r0w1 = 1'b1; s.w_rand = 3'd5; s.i_rand = 3'd6;
    applyStimulus(s);
    afterEdge();
    checkOutput("rand_w_load", 32'(b_w_rand_num_reg), 32'd5);
    checkOutput("rand_i_load", 32'(b_i_rand_num_reg), 32'd6);
    s.r_en = 1'b0; s.w_rand = 3'd1; s.i_rand = 3'd2;
    applyStimulus(s);
    afterEdge();
    checkOutput("rand_w_hold", 32'(b_w_rand_num_reg), 32'd5);
    checkOutput("m_end_idle",  32'(M_end_reg),        32'd0);

    // Directed streams: positive, negative, comparator gating.
    runStream(16, 3'd7, 1'b0, 0, 8'd63);
    runStream(16, 3'd7, 1'b0, 1, 8'd0);
    runStream(8,  3'd3, 1'b0, 2, 8'd0);
    afterEdge();
    checkOutput("w_after_stream", 32'(b_weight_abs_reg), 32'd3);

    // Reset mid-stream discards the partial accumulation.
    s = '0;
    s.w_en = 1'b1; s.w_r0w1 = 1'b1; s.w_abs = 3'd7;
    applyStimulus(s);
    for (int i = 0; i < 5; i++) begin
      s = '0;
      s.in_en = 1'b1; s.in_r0w1 = 1'b1; s.in_abs = 1'b1;
      applyStimulus(s);
    end
    s = '0;
    s.resetn = 1'b1;
    applyStimulus(s);
    afterEdge();
    checkOutput("midrst_out",   32'(b_output_reg),     32'd0);
    checkOutput("midrst_w_abs", 32'(b_weight_abs_reg), 32'd0);
    checkOutput("midrst_in",    32'(u_input_abs_reg),  32'd0);
    runStream(4, 3'd5, 1'b0, 0, 8'd10);

    // Long positive stream that pushes past the signed range.
    runStream(130, 3'd7, 1'b0, 0, 8'd127);
    runStream(120, 3'd7, 1'b1, 1, 8'h81);

    // Randomized streams.
    for (int n = 0; n < 40; n++)
      runStream(int'($urandom_range(1, 24)), 3'($urandom), 1'($urandom), 3,
                8'($urandom));

    // Let the monitor drain, bounded.
    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 100) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (expQ.size() != 0) begin
      nVec++;
      nMiss++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0",
               expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
